// File: rtl/arbiter_rr_n.sv
// N-requester round-robin arbiter with registered, Moore-style grants.
// Optional hold timeout with forced handover: define ARB_TIMEOUT_EN.
module arbiter_rr_n #(
  parameter  int N        = 3,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
`ifdef ARB_TIMEOUT_EN
  output logic           forced,
`endif
  output logic [IDW-1:0] gnt_id
);

  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad
    $error("arbiter_rr_n: parameter out of range");
  end

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [IDW-1:0] last;
  logic [N-1:0]   cand;
  logic           found;
  logic [IDW-1:0] nxt;
  logic           keep;
  logic           force_h;
  int             k;

  // Owner is excluded from the scan, so a release or
  // forced handover never re-grants the same requester.
  always_comb begin
    cand  = req & ~gnt;
    found = 1'b0;
    nxt   = '0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = int'(last) + i;
      if (k >= N) k = k - N;
      if (!found && cand[k[IDW-1:0]]) begin
        found = 1'b1;
        nxt   = k[IDW-1:0];
      end
    end
  end

  assign keep = (|gnt) && req[last];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HMAX = 8'(MAX_HOLD);
  logic [7:0] hold_cnt;

  assign force_h = keep && found &&
                   (hold_cnt >= HMAX - 8'd1);
`else
  assign force_h = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      last      <= IDW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      forced    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      forced <= 1'b0;
`endif
      if (keep && !force_h) begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt < HMAX)
          hold_cnt <= hold_cnt + 8'd1;
`endif
      end else if (found) begin
        gnt       <= ONE << nxt;
        gnt_valid <= 1'b1;
        gnt_id    <= nxt;
        last      <= nxt;
`ifdef ARB_TIMEOUT_EN
        hold_cnt  <= '0;
        forced    <= force_h;
`endif
      end else begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt  <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Self-checking bench for arbiter_rr_n (N=3), directed + random.
// Timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_arbiter_rr_n;

  localparam int N  = 3;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       forced;

  int checks = 0;
  int errors = 0;

  int owner;
  int mlast;
  int mhold;
  bit mforced;

  always #5 clk = ~clk;

  arbiter_rr_n #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
`ifdef ARB_TIMEOUT_EN
    .forced    (forced),
`endif
    .gnt_id    (gnt_id)
  );

`ifndef ARB_TIMEOUT_EN
  assign forced = 1'b0;
`endif

  task automatic model_reset();
    owner   = -1;
    mlast   = N - 1;
    mhold   = 0;
    mforced = 0;
  endtask

  // Rules: owner keeps while requesting (unless hold expired and
  // someone waits); otherwise first other requester after last.
  task automatic model_edge(input logic [2:0] r);
    bit kp;
    bit frc;
    int nx;
    kp = (owner >= 0) && r[owner];
    nx = -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (mlast + i) % N;
      if (nx < 0 && c != owner && r[c]) nx = c;
    end
    frc = 0;
`ifdef ARB_TIMEOUT_EN
    frc = kp && (nx >= 0) && (mhold >= MH - 1);
`endif
    mforced = 0;
    if (kp && !frc) begin
      if (mhold < MH) mhold++;
    end else if (nx >= 0) begin
      owner   = nx;
      mlast   = nx;
      mhold   = 0;
      mforced = frc;
    end else begin
      owner = -1;
      mhold = 0;
    end
  endtask

  function automatic logic [2:0] exp_gnt();
    return (owner < 0) ? 3'b000 : 3'(1 << owner);
  endfunction

  task automatic step(input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 3'b000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_init gnt=%b v=%b id=%0d want 000/0/0",
               gnt, gnt_valid, gnt_id);
    end
    rst_n = 1'b1;
    repeat (3) step(3'b111);
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset_owner gnt=%b want 001", gnt);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 3'b000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_async gnt=%b v=%b id=%0d want 000/0/0",
               gnt, gnt_valid, gnt_id);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b111);
    checks++;
    if (gnt !== 3'b001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant gnt=%b id=%0d want 001/0",
               gnt, gnt_id);
    end
    step(3'b000);
    checks++;
    if (gnt !== 3'b000 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle gnt=%b want 000", gnt);
    end
  endtask

  task automatic test_single();
    step(3'b100);
    checks++;
    if (gnt !== 3'b100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant gnt=%b id=%0d want 100/2", gnt, gnt_id);
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b100);
      checks++;
      if (gnt !== 3'b100) begin
        errors++;
        $display("FAIL single_hold%0d gnt=%b want 100", i, gnt);
      end
    end
    step(3'b000);
    checks++;
    if (gnt !== 3'b000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release gnt=%b id=%0d v=%b want 000/0/0",
               gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] rq [4];
    logic [2:0] eg [4];
    rq = '{3'b111, 3'b110, 3'b101, 3'b011};
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 4; i++) begin
      step(rq[i]);
      checks++;
      if (gnt !== eg[i] || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation%0d gnt=%b v=%b want %b/1",
                 i, gnt, gnt_valid, eg[i]);
      end
    end
    step(3'b000);
  endtask

  task automatic test_wrap();
    step(3'b100);
    step(3'b000);
    step(3'b011);
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL wrap_first gnt=%b want 001", gnt);
    end
    step(3'b010);
    checks++;
    if (gnt !== 3'b010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL wrap_fair gnt=%b id=%0d want 010/1", gnt, gnt_id);
    end
    step(3'b000);
  endtask

  task automatic test_lost_pulse();
    logic [2:0] rq [5];
    logic [2:0] eg [5];
    rq = '{3'b001, 3'b011, 3'b001, 3'b001, 3'b000};
    eg = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    for (int i = 0; i < 5; i++) begin
      step(rq[i]);
      checks++;
      if (gnt !== eg[i]) begin
        errors++;
        $display("FAIL lost_pulse%0d gnt=%b want %b", i, gnt, eg[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    for (int i = 0; i < 400; i++) begin
      r = 3'($urandom_range(0, 7));
      if (owner >= 0 && $urandom_range(0, 3) != 0) r[owner] = 1'b1;
      step(r);
      checks++;
      if (gnt !== exp_gnt() || gnt_valid !== (owner >= 0) ||
          gnt_id !== ((owner < 0) ? 2'd0 : 2'(owner)) ||
          forced !== mforced) begin
        errors++;
        $display("FAIL random%0d req=%b gnt=%b v=%b id=%0d f=%b want %b/%0d",
                 i, r, gnt, gnt_valid, gnt_id, forced, exp_gnt(), owner);
      end
    end
    step(3'b000);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(3'b011);
      checks++;
      if (gnt !== 3'b001 || forced !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold%0d gnt=%b f=%b want 001/0",
                 i, gnt, forced);
      end
    end
    step(3'b011);
    checks++;
    if (gnt !== 3'b010 || forced !== 1'b1) begin
      errors++;
      $display("FAIL timeout_force gnt=%b f=%b want 010/1", gnt, forced);
    end
    step(3'b011);
    checks++;
    if (gnt !== 3'b010 || forced !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse gnt=%b f=%b want 010/0", gnt, forced);
    end
    step(3'b000);
    for (int i = 0; i < 12; i++) begin
      step(3'b001);
      checks++;
      if (gnt !== 3'b001 || forced !== 1'b0) begin
        errors++;
        $display("FAIL timeout_alone%0d gnt=%b f=%b want 001/0",
                 i, gnt, forced);
      end
    end
    step(3'b000);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_lost_pulse();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_n.md
# arbiter_rr_n

Parametrised N-requester round-robin arbiter with registered, Moore-style grant outputs. It generalises the team's fixed 3-input arbiter state machine: the state is held internally, the requester count is a parameter, and a rotating priority pointer gives starvation-free access. It sits in front of any shared resource (bus, memory port, output channel) and gives exactly one owner a grant, held until that owner releases its request.

## Interface
- N, default 3: number of requesters; legal range 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles while others wait. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
- IDW, localparam = max(1, clog2(N)): width of GNT_ID.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous and active-low.
- REQ  input  N  request vector; bit i = requester i; level-sensitive.
- GNT  output  N  one-hot grant, or all-zero when idle; registered.
- GNT_VALID  output  1  OR of GNT; registered.
- GNT_ID  output  IDW  index of the granted requester; 0 when idle; registered.
- FORCED  output  1  one-cycle pulse on a timeout-forced handover. Present only with ARB_TIMEOUT_EN.

## Operation
- State: GNT register, pointer LAST (IDW bits, last requester granted), hold counter HOLD_CNT (8 bits, ARB_TIMEOUT_EN only).
- Two states, derived from GNT: IDLE (GNT==0) and OWNED (GNT one-hot).
- IDLE -> OWNED: any REQ bit set. Scan REQ starting at (LAST+1) mod N, wrapping, and grant the first set bit. LAST := the granted index.
- OWNED, REQ[owner]=1: keep the grant. Without the macro this holds indefinitely.
- OWNED, REQ[owner]=0: release. Scan from owner+1 in the same edge.
  - Another requester pending: it gets the grant. Back-to-back handover with no idle cycle.
  - None pending: -> IDLE.
- The scan never revisits the releasing owner in the same edge, because its REQ bit is 0.
- Grant changes only at rising CLK edges. Outputs never depend combinationally on REQ.
- Invariant: at most one GNT bit set. GNT_ID always matches the set GNT bit. GNT_VALID == |GNT.
- Requests are not latched. A REQ pulse that drops before it is granted is lost.
- LAST wraps from N-1 to 0. For non-power-of-2 N, indices >= N are never produced.

## Timing
- Reset (RST_N low, asynchronous): GNT=0, GNT_VALID=0, GNT_ID=0, LAST=N-1 (so the first scan starts at requester 0), HOLD_CNT=0, FORCED=0.
- Reset release mid-operation: the arbiter restarts from IDLE. Any previous owner must re-request.
- REQ-to-GNT latency: 1 cycle. REQ sampled at edge k gives GNT visible after edge k.
- Release-to-next-grant: 1 cycle. The owner's REQ low at edge k moves GNT to the next requester at edge k.
- Simultaneous requests from IDLE: the lowest index at or after LAST+1, wrapping, wins.
- Simultaneous release by the owner and a new request: the new request is considered in the same scan.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - HOLD_CNT resets to 0 on every new grant and increments each OWNED cycle, saturating at MAX_HOLD.
  - If HOLD_CNT==MAX_HOLD-1, the owner still requests, and another requester is pending, the next edge forces a handover to the next requester in scan order.
  - FORCED pulses high for exactly that one cycle (registered alongside the new GNT).
  - If no other requester is pending, the owner keeps the grant and HOLD_CNT saturates.
  - The FORCED port exists.
- Undefined:
  - No counter, no FORCED port.
  - The owner holds until it drops REQ.

## Test plan
- Reset: assert RST_N=0 mid-grant with REQ=3'b111 -> GNT=0, GNT_VALID=0, GNT_ID=0 immediately. After release, first grant is GNT=3'b001.
- Single request: N=3, REQ=3'b100 from idle -> GNT=3'b100, GNT_ID=2 one cycle later; holds while REQ stays high; REQ=0 -> GNT=0 next cycle.
- Rotation: REQ=3'b111 held, each owner drops its bit for one cycle after being granted -> grant order 0,1,2,0 with no idle cycles between grants.
- Wrap and fairness: LAST=2, REQ=3'b011 -> GNT=3'b001. After release with REQ=3'b011 still pending -> GNT=3'b010, not 3'b001 again.
- Lost pulse: REQ[1] high for one cycle while requester 0 owns -> no grant ever issued to 1.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): REQ=3'b011 held constantly -> GNT=3'b001 for exactly 4 cycles, then GNT=3'b010 with FORCED=1 for one cycle. With REQ=3'b001 only -> grant held indefinitely, FORCED stays 0.
